// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  // Dividend/quotient width and divisor/remainder width.
  localparam int DW = 8;
  localparam int VW = 4;

  // Width of the bit counter that walks the quotient bits.
  localparam int CW = $clog2(DW);

  // Result presented when the captured divisor is zero.
  localparam logic [DW-1:0] Q_DIV0 = 8'hFF;
  localparam logic [VW-1:0] R_DIV0 = 4'hF;

  // Control states of the divider.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential divider.
interface seq_divider_if;
  import seq_divider_pkg::*;

  logic          start;
  logic [DW-1:0] N;
  logic [VW-1:0] D;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          busy;
  logic          done;
  logic          div0;

  // The requester drives operands and start.
  modport master (
    output start, N, D,
    input  Q, R, busy, done, div0
  );

  // The divider consumes operands and returns the result.
  modport slave (
    input  start, N, D,
    output Q, R, busy, done, div0
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only when it fits.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [VW:0]   t,
  input  logic [VW-1:0] d,
  output logic [VW:0]   rem_next,
  output logic          qbit
);

  logic [VW:0] diff;

  // Plain 5-bit subtract; the borrow is never needed because the
  // difference is only kept when t >= d.
  always_comb begin
    diff     = t - {1'b0, d};
    qbit     = (t >= {1'b0, d});
    rem_next = qbit ? diff : t;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential 8-by-4 unsigned restoring divider, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  seq_divider_if.slave bus
);

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          last_bit;

  logic [CW-1:0] cnt;
  logic [DW-1:0] nq;
  logic [VW-1:0] rem;
  logic [VW-1:0] dreg;

  logic [VW:0]   t;
  logic [VW:0]   rem_next;
  logic          qbit;
  logic          unused_rem_msb;

  logic [DW-1:0] q_reg;
  logic [VW-1:0] r_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          div0_reg;

  // The dividend shifts out MSB first while quotient bits shift in at
  // the bottom, so after DW steps nq holds the whole quotient.
  assign t = {rem, nq[DW-1]};

  div_step u_step (
    .t        (t),
    .d        (dreg),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // After a step the remainder is below the divisor, so its top bit is
  // always zero and only the low VW bits are kept.
  assign unused_rem_msb = rem_next[VW];

  assign last_bit = (cnt == CW'(DW - 1));

  // Next-state logic; start is honoured only when not iterating.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        next_state = IDLE;
        if (bus.start) begin
          accept     = 1'b1;
          next_state = (bus.D == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_bit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Working registers: capture on accept, shift/subtract while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      nq   <= '0;
      rem  <= '0;
      dreg <= '0;
    end else if (accept) begin
      cnt  <= '0;
      nq   <= bus.N;
      rem  <= '0;
      dreg <= bus.D;
    end else if (state == RUN) begin
      cnt  <= cnt + CW'(1);
      nq   <= {nq[DW-2:0], qbit};
      rem  <= rem_next[VW-1:0];
    end
  end

  // Result and status registers; Q/R/div0 change only on a result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      r_reg    <= '0;
      div0_reg <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= (next_state == RUN);
      done_reg <= (next_state == DONE);
      if (accept && (bus.D == '0)) begin
        q_reg    <= Q_DIV0;
        r_reg    <= R_DIV0;
        div0_reg <= 1'b1;
      end else if ((state == RUN) && last_bit) begin
        q_reg    <= {nq[DW-2:0], qbit};
        r_reg    <= rem_next[VW-1:0];
        div0_reg <= 1'b0;
      end
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.div0 = div0_reg;

endmodule
